pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline control block for the 5-stage MIPS core. Merges stall requests from IF, ID (load-use), EX (multi-cycle ops) and MEM (data-bus wait) into one per-stage stall vector. Sequences exception/ERET flushes, deferring a flush that arrives while MEM is stalled on a bus transaction. Keeps stall and flush performance counters and a stall watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of consecutive stalled cycles that raises `timeout_o`; legal range 1..65535.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset; state is reset while `rst`==0 at a rising `clk`.
- `stallreq_if_i` in 1: instruction fetch not ready.
- `stallreq_id_i` in 1: load-use hazard reported by ID.
- `stallreq_ex_i` in 1: multi-cycle EX operation busy.
- `stallreq_mem_i` in 1: data bus transaction outstanding.
- `excp_req_i` in 1: exception or ERET committed in MEM; level, sampled every cycle.
- `excp_target_i` in 32 (Inst_addr_t): handler address or EPC for `excp_req_i`.
- `stall_o` out 6: per-stage stall; bit 0 PC, bit 1 IF, bit 2 ID, bit 3 EX, bit 4 MEM, bit 5 WB.
- `flush_o` out 1: clear all pipeline registers this cycle.
- `new_pc_o` out 32: PC to load when `flush_o`=1; 0 otherwise.
- `excp_pending_o` out 1: an exception is captured and waiting for MEM to release.
- `timeout_o` out 1: the stall run length has reached `TIMEOUT_CYCLES`.
- `stall_cycles_o` out 32: total cycles with `stall_o[0]`=1.
- `flush_count_o` out 16: total flush cycles.

## Operation
- States: RUN, PEND. Reset → RUN. Holding registers: `pend_pc` (32), `run_cnt` (16, saturating), `stall_cycles` (32), `flush_cnt` (16).
- `stall_o`, `flush_o` and `new_pc_o` are combinational from the state and inputs. All three are forced to 0 while `rst`==0.
- RUN, `excp_req_i`=1, `stallreq_mem_i`=0: `flush_o`=1, `new_pc_o`=`excp_target_i`, `stall_o`=0. State stays RUN.
- RUN, `excp_req_i`=1, `stallreq_mem_i`=1:
  - `flush_o`=0 and `stall_o`=6'b011111.
  - `pend_pc` ← `excp_target_i`; state → PEND.
- RUN, `excp_req_i`=0: stall vector set by the highest active request:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- PEND, `stallreq_mem_i`=1: `stall_o`=6'b011111, `flush_o`=0. All other requests, including new `excp_req_i`, are ignored; the first captured exception wins.
- PEND, `stallreq_mem_i`=0: `flush_o`=1, `new_pc_o`=`pend_pc`, `stall_o`=0. State → RUN.
- `excp_pending_o` = (state==PEND). It is registered, so it goes high the cycle after capture and low the cycle after the deferred flush.
- `run_cnt`:
  - increments, saturating at `TIMEOUT_CYCLES`, on each edge where `stall_o`≠0;
  - clears on an edge where `stall_o`=0 (flush cycles included).
- `timeout_o` = (`run_cnt` == `TIMEOUT_CYCLES`); registered.
- `stall_cycles` increments when `stall_o[0]`=1 and wraps from 2^32−1 to 0.
- `flush_cnt` increments when `flush_o`=1 and wraps from 0xFFFF to 0.

## Timing
- Reset (`rst`==0 at an edge):
  - state=RUN, `pend_pc`=0, `run_cnt`=0, all counters=0.
  - `excp_pending_o`=0, `timeout_o`=0, `stall_o`=0, `flush_o`=0, `new_pc_o`=0.
- Reset in PEND discards the pending exception; no flush is issued after reset.
- Stall and flush latency from request is 0 cycles (same cycle).
- Counter and status updates appear 1 cycle after the causing cycle.
- `flush_o` is high for exactly 1 cycle per exception. While `excp_req_i` stays high in RUN with MEM free, a flush is issued every cycle; upstream drops the request after the flush.
- A deferred flush is issued in the first cycle `stallreq_mem_i` is low after capture. Minimum deferral is 1 cycle.
- Timeout: with `stall_o`≠0 continuously from cycle 0, `timeout_o` rises in cycle `TIMEOUT_CYCLES`. It falls 1 cycle after the first unstalled cycle.

## Test plan
- Request priority: from reset, raise `stallreq_id_i` and `stallreq_if_i` for 3 cycles → `stall_o`=6'b000111 for those 3 cycles; `stall_cycles_o`=3 afterwards; `flush_o`=0 throughout.
- Immediate flush: RUN, `excp_req_i`=1 with `excp_target_i`=0xBFC00380 and `stallreq_ex_i`=1 for 1 cycle → same cycle `flush_o`=1, `new_pc_o`=0xBFC00380, `stall_o`=0; next cycle `flush_count_o`=1.
- Deferred flush:
  - Stimulus: `stallreq_mem_i`=1 for cycles 0–4, `excp_req_i`=1 with target 0x80000180 at cycle 1, a second `excp_req_i` with target 0x11111111 at cycle 3.
  - Required: `stall_o`=6'b011111 in cycles 0–4; `excp_pending_o`=1 in cycles 2–5; flush in cycle 5 with `new_pc_o`=0x80000180; `flush_o`=1 only in cycle 5.
- Reset mid-PEND: enter PEND, then hold `rst`=0 for 1 edge while `stallreq_mem_i` drops → no flush; `excp_pending_o`=0; all counters 0.
- Watchdog with `TIMEOUT_CYCLES`=4:
  - `stallreq_ex_i`=1 for 6 cycles → `timeout_o` high in cycles 4–6, low at cycle 7.
  - 3 stalled cycles, 1 free cycle, then 3 more stalled cycles → `timeout_o` never rises.
- Counter wrap: preload `stall_cycles` to 0xFFFFFFFF, then 1 stalled cycle → `stall_cycles_o`=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception commit in, stall/flush
// vector and status counters out. slave is the control block, master the pipeline.
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        excp_req_i;
  logic [31:0] excp_target_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        excp_pending_o;
  logic        timeout_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  excp_req_i, excp_target_i,
    output stall_o, flush_o, new_pc_o, excp_pending_o, timeout_o,
    output stall_cycles_o, flush_count_o
  );

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output excp_req_i, excp_target_i,
    input  stall_o, flush_o, new_pc_o, excp_pending_o, timeout_o,
    input  stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush control for the 5-stage core, with exception deferral while
// MEM waits on the data bus, a stall watchdog and stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_IF  = 6'b000011;

  typedef enum logic [0:0] {RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        timeout_q, timeout_d;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall_c   = '0;
    flush_c   = 1'b0;
    new_pc_c  = '0;

    unique case (state_q)
      RUN: begin
        if (bus.excp_req_i) begin
          if (bus.stallreq_mem_i) begin
            // MEM owns the bus: hold the pipe and replay the flush once it frees up.
            stall_c   = STALL_MEM;
            pend_pc_d = bus.excp_target_i;
            state_d   = PEND;
          end else begin
            flush_c  = 1'b1;
            new_pc_c = bus.excp_target_i;
          end
        end else if (bus.stallreq_mem_i) begin
          stall_c = STALL_MEM;
        end else if (bus.stallreq_ex_i) begin
          stall_c = STALL_EX;
        end else if (bus.stallreq_id_i) begin
          stall_c = STALL_ID;
        end else if (bus.stallreq_if_i) begin
          stall_c = STALL_IF;
        end
      end
      PEND: begin
        if (bus.stallreq_mem_i) begin
          stall_c = STALL_MEM;
        end else begin
          flush_c  = 1'b1;
          new_pc_c = pend_pc_q;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (!rst) begin
      stall_c  = '0;
      flush_c  = 1'b0;
      new_pc_c = '0;
    end
  end

  always_comb begin
    run_cnt_d = '0;
    if (stall_c != 6'd0) begin
      run_cnt_d = (run_cnt_q == TIMEOUT_VAL) ? run_cnt_q : run_cnt_q + 16'd1;
    end
    timeout_d      = (run_cnt_d == TIMEOUT_VAL);
    stall_cycles_d = stall_c[0] ? stall_cycles_q + 32'd1 : stall_cycles_q;
    flush_cnt_d    = flush_c ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      pend_pc_q      <= '0;
      run_cnt_q      <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pend_pc_q      <= pend_pc_d;
      run_cnt_q      <= run_cnt_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.stall_o        = stall_c;
  assign bus.flush_o        = flush_c;
  assign bus.new_pc_o       = new_pc_c;
  assign bus.excp_pending_o = (state_q == PEND);
  assign bus.timeout_o      = timeout_q;
  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_count_o  = flush_cnt_q;

endmodule
